// File: rtl/vector_instr_scheduler.sv
// Front-end sequencer: round-robin arbitration of two requesters into a FIFO,
// single-op issue to vector_processor with completion tracking and watchdog abort.
module vector_instr_scheduler #(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          req0_valid,
  input  logic [DATA_WIDTH-1:0]         req0_instr,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [DATA_WIDTH-1:0]         req1_instr,
  output logic                          req1_ready,
  output logic                          vp_enable,
  output logic [DATA_WIDTH-1:0]         vp_instruction,
  input  logic [DATA_WIDTH-1:0]         vp_data_out,
  input  logic                          vp_data_valid,
  output logic                          vp_flush,
  output logic                          rsp_valid,
  output logic                          rsp_src,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          timeout_err,
  input  logic                          clear_err
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int RCW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                  r_state;
  logic [DATA_WIDTH:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wptr;
  logic [AW-1:0]           r_rptr;
  logic [CW-1:0]           r_count;
  logic                    r_rr;
  logic [RCW-1:0]          r_run_cnt;
  logic [DATA_WIDTH-1:0]   r_cur_instr;
  logic                    r_cur_src;
  logic                    r_rsp_valid;
  logic                    r_rsp_src;
  logic [DATA_WIDTH-1:0]   r_rsp_data;
  logic                    r_rsp_err;
  logic                    r_flush;
  logic                    r_timeout_err;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_grant0;
  logic                    w_grant1;
  logic                    w_push;
  logic                    w_pop;
  logic [DATA_WIDTH:0]     w_push_data;
  logic                    w_complete;
  logic                    w_timeout;

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);

  // r_rr names the requester preferred when both are valid
  assign w_grant0    = ~w_full & req0_valid & (~req1_valid | ~r_rr);
  assign w_grant1    = ~w_full & req1_valid & (~req0_valid |  r_rr);
  assign req0_ready  = w_grant0;
  assign req1_ready  = w_grant1;
  assign w_push      = w_grant0 | w_grant1;
  assign w_push_data = w_grant1 ? {1'b1, req1_instr} : {1'b0, req0_instr};
  assign w_pop       = (r_state == S_IDLE) & ~w_empty;

  // run_cnt==0 ignores the processor's stale data_valid from the previous op
  assign w_complete = (r_state == S_RUN) & vp_data_valid & (r_run_cnt != '0);
  assign w_timeout  = (r_state == S_RUN) & ~w_complete &
                      (r_run_cnt == RCW'(TIMEOUT_CYCLES - 1));
  assign vp_enable  = (r_state == S_RUN) & ~w_complete;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= w_push_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rr    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
        r_rr   <= ~w_grant1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_run_cnt     <= '0;
      r_cur_instr   <= '0;
      r_cur_src     <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_src     <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_err     <= 1'b0;
      r_flush       <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_flush     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_cur_src, r_cur_instr} <= r_mem[r_rptr];
            r_run_cnt <= '0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_complete) begin
            r_rsp_valid <= 1'b1;
            r_rsp_src   <= r_cur_src;
            r_rsp_data  <= vp_data_out;
            r_rsp_err   <= 1'b0;
            r_state     <= S_IDLE;
          end else if (w_timeout) begin
            r_flush     <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_rsp_src   <= r_cur_src;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_run_cnt <= r_run_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_timeout)      r_timeout_err <= 1'b1;
      else if (clear_err) r_timeout_err <= 1'b0;
    end
  end

  assign vp_instruction = r_cur_instr;
  assign vp_flush       = r_flush;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_src        = r_rsp_src;
  assign rsp_data       = r_rsp_data;
  assign rsp_err        = r_rsp_err;
  assign fifo_count     = r_count;
  assign busy           = (r_state == S_RUN) | ~w_empty;
  assign timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_vector_instr_scheduler.sv
// Bench for vector_instr_scheduler: queue-based reference model plus a small
// processor model that holds data_valid stale between ops and hangs on 0x..FF.
module tb_vector_instr_scheduler;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TO    = 16;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_instr, req1_instr;
  logic          req0_ready, req1_ready;
  logic          vp_enable;
  logic [DW-1:0] vp_instruction;
  logic [DW-1:0] vp_data_out;
  logic          vp_data_valid;
  logic          vp_flush;
  logic          rsp_valid, rsp_src, rsp_err;
  logic [DW-1:0] rsp_data;
  logic [2:0]    fifo_count;
  logic          busy, timeout_err, clear_err;

  vector_instr_scheduler #(
    .DATA_WIDTH    (DW),
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req0_valid    (req0_valid),
    .req0_instr    (req0_instr),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_instr    (req1_instr),
    .req1_ready    (req1_ready),
    .vp_enable     (vp_enable),
    .vp_instruction(vp_instruction),
    .vp_data_out   (vp_data_out),
    .vp_data_valid (vp_data_valid),
    .vp_flush      (vp_flush),
    .rsp_valid     (rsp_valid),
    .rsp_src       (rsp_src),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .fifo_count    (fifo_count),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .clear_err     (clear_err)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [DW:0]   q[$];
  bit            m_run, m_rr, m_cur_src, m_rsp_valid, m_rsp_src, m_rsp_err, m_flush, m_terr;
  logic [DW-1:0] m_cur_instr, m_rsp_data;
  int            m_cnt;

  // processor model state
  bit            p_valid, p_prev;
  logic [DW-1:0] p_data;
  int            p_rem;

  // values sampled in the most recent cycle
  logic          s_rdy0, s_en, s_rsp_valid, s_rsp_src, s_rsp_err, s_flush, s_terr;
  logic [DW-1:0] s_instr, s_rsp_data;
  logic [2:0]    s_cnt;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int latency(input logic [DW-1:0] instr);
    if (instr[7:0] == 8'hFF) return 1000;
    return int'(instr[1:0]) + 1;
  endfunction

  task automatic model_clear();
    q.delete();
    m_run = 0; m_rr = 0; m_cur_src = 0; m_cur_instr = '0; m_cnt = 0;
    m_rsp_valid = 0; m_rsp_src = 0; m_rsp_err = 0; m_rsp_data = '0;
    m_flush = 0; m_terr = 0;
    p_valid = 0; p_prev = 0; p_rem = 0; p_data = '0;
    vp_data_valid = 0; vp_data_out = '0;
  endtask

  // Entered and left at a falling edge.
  task automatic cycle(input bit v0, input logic [DW-1:0] i0, input bit v1,
                       input logic [DW-1:0] i1, input bit clr,
                       output bit acc0, output bit acc1);
    bit full, r0, r1, cmp, tmo, en, fl;
    logic [DW:0] e;
    req0_valid = v0; req0_instr = i0;
    req1_valid = v1; req1_instr = i1;
    clear_err  = clr;
    #1;
    full = (q.size() == DEPTH);
    r0   = !full && v0 && (!v1 || !m_rr);
    r1   = !full && v1 && (!v0 ||  m_rr);
    cmp  = m_run && vp_data_valid && (m_cnt >= 1);
    tmo  = m_run && !cmp && (m_cnt == TO - 1);
    en   = m_run && !cmp;
    check("req0_ready", 64'(req0_ready), 64'(r0));
    check("req1_ready", 64'(req1_ready), 64'(r1));
    check("vp_enable",  64'(vp_enable),  64'(en));
    if (m_run) check("vp_instruction", 64'(vp_instruction), 64'(m_cur_instr));
    check("rsp_valid",  64'(rsp_valid),  64'(m_rsp_valid));
    if (m_rsp_valid) begin
      check("rsp_src",  64'(rsp_src),  64'(m_rsp_src));
      check("rsp_data", 64'(rsp_data), 64'(m_rsp_data));
      check("rsp_err",  64'(rsp_err),  64'(m_rsp_err));
    end
    check("vp_flush",    64'(vp_flush),    64'(m_flush));
    check("fifo_count",  64'(fifo_count),  64'(q.size()));
    check("busy",        64'(busy),        64'(m_run || q.size() != 0));
    check("timeout_err", 64'(timeout_err), 64'(m_terr));
    s_rdy0 = req0_ready; s_en = vp_enable; s_instr = vp_instruction;
    s_rsp_valid = rsp_valid; s_rsp_src = rsp_src; s_rsp_data = rsp_data;
    s_rsp_err = rsp_err; s_flush = vp_flush; s_cnt = fifo_count; s_terr = timeout_err;
    acc0 = r0; acc1 = r1;
    fl = m_flush;

    @(posedge clock); #1;
    m_rsp_valid = 0;
    m_flush     = 0;
    if (!m_run) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        m_cur_src = e[DW]; m_cur_instr = e[DW-1:0];
        m_run = 1; m_cnt = 0;
      end
    end else if (cmp) begin
      m_rsp_valid = 1; m_rsp_src = m_cur_src; m_rsp_data = vp_data_out; m_rsp_err = 0;
      m_run = 0;
    end else if (tmo) begin
      m_rsp_valid = 1; m_rsp_src = m_cur_src; m_rsp_data = '0; m_rsp_err = 1;
      m_flush = 1; m_run = 0;
    end else begin
      m_cnt++;
    end
    if (tmo)      m_terr = 1;
    else if (clr) m_terr = 0;
    if (r0) begin q.push_back({1'b0, i0}); m_rr = 1; end
    else if (r1) begin q.push_back({1'b1, i1}); m_rr = 0; end

    // processor: restarts on first enabled cycle, valid lingers until then
    if (fl) begin
      p_valid = 0; p_rem = 0; p_prev = 0;
    end else begin
      if (en) begin
        if (!p_prev) begin
          p_valid = 0;
          p_rem   = latency(m_cur_instr);
        end else if (p_rem > 0) begin
          p_rem--;
          if (p_rem == 0) begin
            p_valid = 1;
            p_data  = m_cur_instr + 32'd1;
          end
        end
      end
      p_prev = en;
    end
    vp_data_valid = p_valid;
    vp_data_out   = p_valid ? p_data : $urandom;
    @(negedge clock);
  endtask

  task automatic idle_cycles(input int n);
    bit a0, a1;
    for (int i = 0; i < n; i++) cycle(0, '0, 0, '0, 0, a0, a1);
  endtask

  task automatic do_reset();
    reset_n = 0;
    req0_valid = 0; req1_valid = 0; req0_instr = '0; req1_instr = '0; clear_err = 0;
    model_clear();
    #1;
    check("rst_enable",  64'(vp_enable),      64'd0);
    check("rst_instr",   64'(vp_instruction), 64'd0);
    check("rst_rsp",     64'({rsp_valid, rsp_src, rsp_err}), 64'd0);
    check("rst_rspdata", 64'(rsp_data),       64'd0);
    check("rst_flush",   64'(vp_flush),       64'd0);
    check("rst_count",   64'(fifo_count),     64'd0);
    check("rst_busy",    64'(busy),           64'd0);
    check("rst_terr",    64'(timeout_err),    64'd0);
    check("rst_ready",   64'({req0_ready, req1_ready}), 64'd0);
    @(negedge clock); @(negedge clock);
    reset_n = 1;
  endtask

  task automatic wait_drain(input string nm, input int bound);
    int k;
    k = 0;
    while ((m_run || q.size() != 0 || m_rsp_valid) && k < bound) begin
      idle_cycles(1);
      k++;
    end
    if (k >= bound) begin
      n_vec++; n_err++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", nm, bound);
    end
  endtask

  initial begin
    bit a0, a1;
    int i0, i1, k, nacc;
    reset_n = 0;
    @(negedge clock);
    do_reset();

    // single ADD with hand-computed timing
    cycle(1, 32'h3120_0300, 0, '0, 0, a0, a1);
    check("add_ready_lit", 64'(s_rdy0), 64'd1);
    cycle(0, '0, 0, '0, 0, a0, a1);
    check("add_count_lit", 64'(s_cnt), 64'd1);
    check("add_idle_en",   64'(s_en),  64'd0);
    cycle(0, '0, 0, '0, 0, a0, a1);
    check("add_issue_en",    64'(s_en),    64'd1);
    check("add_issue_instr", 64'(s_instr), 64'h3120_0300);
    cycle(0, '0, 0, '0, 0, a0, a1);
    check("add_run_en", 64'(s_en), 64'd1);
    cycle(0, '0, 0, '0, 0, a0, a1);
    check("add_done_en", 64'(s_en), 64'd0);
    cycle(0, '0, 0, '0, 0, a0, a1);
    check("add_rsp_valid_lit", 64'(s_rsp_valid), 64'd1);
    check("add_rsp_data_lit",  64'(s_rsp_data),  64'h3120_0301);
    check("add_rsp_src_lit",   64'(s_rsp_src),   64'd0);

    // watchdog: hung op flushes on the 19th cycle counted from the push
    idle_cycles(1);
    cycle(0, '0, 1, 32'h0000_00FF, 0, a0, a1);
    k = 1;
    while (k <= 60) begin
      cycle(0, '0, 0, '0, 0, a0, a1);
      if (s_flush) break;
      k++;
    end
    check("wd_flush_cycle_lit", 64'(k), 64'd18);
    check("wd_rsp_err_lit",  64'(s_rsp_err),  64'd1);
    check("wd_rsp_data_lit", 64'(s_rsp_data), 64'd0);
    check("wd_rsp_src_lit",  64'(s_rsp_src),  64'd1);
    check("wd_terr_lit",     64'(s_terr),     64'd1);
    cycle(1, 32'h0000_0101, 0, '0, 1, a0, a1);
    check("wd_terr_hold_lit", 64'(s_terr), 64'd1);
    cycle(0, '0, 0, '0, 0, a0, a1);
    check("wd_terr_clear_lit", 64'(s_terr), 64'd0);
    wait_drain("wd_drain", 200);

    // round robin: both requesters continuously valid with 6 instrs each
    do_reset();
    i0 = 0; i1 = 0; nacc = 0; k = 0;
    while ((i0 < 6 || i1 < 6) && k < 500) begin
      cycle(i0 < 6, 32'h1000_0000 + i0, i1 < 6, 32'h2000_0002 + i1, 0, a0, a1);
      if (a0 || a1) begin
        if (nacc < 12) check("rr_order_lit", 64'(a1), 64'(nacc % 2));
        nacc++;
      end
      if (a0) i0++;
      if (a1) i1++;
      k++;
    end
    check("rr_all_accepted", 64'(nacc), 64'd12);
    wait_drain("rr_drain", 400);

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      logic [DW-1:0] x0, x1;
      x0 = $urandom; x1 = $urandom;
      if ($urandom_range(15) == 0) x0[7:0] = 8'hFF;
      if ($urandom_range(15) == 0) x1[7:0] = 8'hFF;
      cycle($urandom_range(9) < 6, x0, $urandom_range(9) < 6, x1,
            $urandom_range(9) == 0, a0, a1);
    end
    wait_drain("rand_drain", 800);

    // reset while running with three entries queued
    cycle(1, 32'h0000_00FF, 0, '0, 0, a0, a1);
    k = 0;
    while (!(m_run && q.size() >= 3) && k < 50) begin
      cycle(1, 32'h4000_0000 + k, 0, '0, 0, a0, a1);
      k++;
    end
    check("mid_setup_run", 64'(m_run && q.size() >= 3), 64'd1);
    check("mid_busy_pre",  64'(busy), 64'd1);
    do_reset();
    idle_cycles(6);
    cycle(0, '0, 1, 32'h0000_0001, 0, a0, a1);
    wait_drain("post_reset_drain", 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
